// File: rtl/mem_ctrl.sv
// Byte-serial memory controller shared by instruction fetch and load/store.
// It arbitrates the two requesters and sequences 1/2/4-byte accesses over an 8-bit RAM/IO bus.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_data_o,
  input  logic        ls_req_i,
  input  logic        ls_wr_i,
  input  logic [1:0]  ls_size_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_done_o,
  output logic [31:0] ls_rdata_o,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  input  logic        io_buffer_full_i
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  last;
  logic [31:0] a_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_rdata_q;
  logic [7:0]  dout_q;
  logic        wr_q;
  logic        io_q;
  logic        if_done_q;
  logic        ls_done_q;

  logic [1:0]  cnt_nxt;
  logic [31:0] assembled;
  logic        stall;
  logic        accept_ok;
  logic        ls_io;

  // Index of the final byte for a load/store size; size 3 behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  assign cnt_nxt   = cnt + 2'd1;
  assign assembled = rbuf_q | ({24'd0, mem_din_i} << {cnt, 3'b000});
  assign stall     = io_q & io_buffer_full_i;
  assign accept_ok = ~if_done_q & ~ls_done_q;
  assign ls_io     = (ls_addr_i[17:16] == IO_ADDR_HI);

  assign if_done_o  = if_done_q;
  assign if_data_o  = if_data_q;
  assign ls_done_o  = ls_done_q;
  assign ls_rdata_o = ls_rdata_q;
  assign mem_a_o    = a_q;
  assign mem_dout_o = dout_q;
  // A frozen cycle must not strobe the bus, or an IO byte would be emitted twice.
  assign mem_wr_o   = wr_q & rdy;

  // NOTE: every register here is sequential state, so only non-blocking (<=) assignments are used;
  // blocking ones would make the result depend on statement order and mismatch synthesis.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      last       <= 2'd0;
      a_q        <= 32'd0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
      dout_q     <= 8'd0;
      wr_q       <= 1'b0;
      io_q       <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_ok && ls_req_i) begin
            a_q    <= ls_addr_i;
            cnt    <= 2'd0;
            last   <= last_idx(ls_size_i);
            rbuf_q <= 32'd0;
            if (ls_wr_i) begin
              state   <= LS_WR;
              wdata_q <= ls_wdata_i;
              dout_q  <= ls_wdata_i[7:0];
              io_q    <= ls_io;
              wr_q    <= ~(ls_io & io_buffer_full_i);
            end else begin
              state <= LS_RD;
            end
          end else if (accept_ok && if_req_i && !flush_i) begin
            state  <= IF_RD;
            a_q    <= if_addr_i;
            cnt    <= 2'd0;
            last   <= 2'd3;
            rbuf_q <= 32'd0;
          end
        end

        IF_RD, LS_RD: begin
          if (state == IF_RD && flush_i) begin
            state <= IDLE;
          end else if (cnt == last) begin
            state <= IDLE;
            if (state == IF_RD) begin
              if_data_q <= assembled;
              if_done_q <= 1'b1;
            end else begin
              ls_rdata_q <= assembled;
              ls_done_q  <= 1'b1;
            end
          end else begin
            // The byte addressed last cycle is on mem_din_i now; the next address goes out.
            rbuf_q <= assembled;
            cnt    <= cnt_nxt;
            a_q    <= a_q + 32'd1;
          end
        end

        LS_WR: begin
          if (!wr_q) begin
            // Stalled on a full IO buffer: address and byte are held until it drains.
            if (!stall) wr_q <= 1'b1;
          end else if (cnt == last) begin
            wr_q      <= 1'b0;
            ls_done_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt    <= cnt_nxt;
            a_q    <= a_q + 32'd1;
            dout_q <= wdata_q[{cnt_nxt, 3'b000} +: 8];
            wr_q   <= ~stall;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
